// File: rtl/npu_pkg.sv
// Shared NPU definitions: tile geometry, the conv result tile type and the pooling FSM states.
package npu_pkg;

    localparam int unsigned CONV_OUT_DIM = 4;
    localparam int unsigned POOL_K       = 2;
    localparam int unsigned POOL_OUT_DIM = 2;
    localparam int unsigned TILE_W       = 16;

    // Row-major [row][col] tile of conv results; elements are interpreted as signed.
    typedef logic [CONV_OUT_DIM-1:0][CONV_OUT_DIM-1:0][TILE_W-1:0] conv_tile_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EMIT,
        DONE
    } pool_state_e;

endpackage

// File: rtl/max4_signed.sv
// Combinational signed maximum of four operands, built as a two-level comparator tree.
module max4_signed #(
    parameter int unsigned W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    input  logic signed [W-1:0] d,
    output logic signed [W-1:0] y
);

    logic signed [W-1:0] max_ab;
    logic signed [W-1:0] max_cd;

    always_comb begin
        max_ab = (a > b) ? a : b;
        max_cd = (c > d) ? c : d;
        y      = (max_ab > max_cd) ? max_ab : max_cd;
    end

endmodule

// File: rtl/conv_pool_requant.sv
// Captures a 4x4 conv result tile, then emits its four 2x2 max-pooled, ReLU'd and
// shift-round-saturate requantised values one per valid/ready handshake.
module conv_pool_requant
    import npu_pkg::*;
#(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [CONV_OUT_DIM-1:0][CONV_OUT_DIM-1:0][IN_W-1:0] c_in,
    input  logic [SHIFT_W-1:0]                               shift,
    input  logic                                             relu_en,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [OUT_W-1:0]                                 out_data,
    output logic [1:0]                                       out_idx,
    output logic                                             out_sat,
    output logic                                             busy,
    output logic                                             done
);

    localparam int unsigned R_W = IN_W + 1;
    localparam logic signed [R_W-1:0] Q_MAX = R_W'((1 << (OUT_W - 1)) - 1);
    // Two's complement: inverting the largest positive value gives the most negative one.
    localparam logic signed [R_W-1:0] Q_MIN = ~Q_MAX;

    pool_state_e state_q, state_d;

    logic [CONV_OUT_DIM-1:0][CONV_OUT_DIM-1:0][IN_W-1:0] tile_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               relu_q;
    logic [1:0]         w_q;

    logic [1:0]            row0, row1, col0, col1;
    logic signed [IN_W-1:0] win_a, win_b, win_c, win_d, win_max, m_relu;
    logic signed [R_W-1:0]  rnd, r_sum, q_full;
    logic [OUT_W-1:0]       q_sat;
    logic                   sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = ~rst;
                busy     = 1'b0;
                if (in_valid) state_d = CALC;
            end
            CALC: state_d = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = (w_q == 2'd3) ? DONE : CALC;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window w covers rows {w[1],x} and cols {w[0],x}, giving row-major pooled order.
    always_comb begin
        row0  = {w_q[1], 1'b0};
        row1  = {w_q[1], 1'b1};
        col0  = {w_q[0], 1'b0};
        col1  = {w_q[0], 1'b1};
        win_a = $signed(tile_q[row0][col0]);
        win_b = $signed(tile_q[row0][col1]);
        win_c = $signed(tile_q[row1][col0]);
        win_d = $signed(tile_q[row1][col1]);
    end

    max4_signed #(.W(IN_W)) u_max4 (
        .a(win_a),
        .b(win_b),
        .c(win_c),
        .d(win_d),
        .y(win_max)
    );

    always_comb begin
        m_relu = (relu_q && win_max[IN_W-1]) ? '0 : win_max;
        rnd    = (shift_q != '0) ? (R_W'(1) << (shift_q - SHIFT_W'(1))) : '0;
        r_sum  = {m_relu[IN_W-1], m_relu} + rnd;
        q_full = r_sum >>> shift_q;
        sat    = 1'b0;
        q_sat  = q_full[OUT_W-1:0];
        if (q_full > Q_MAX) begin
            q_sat = Q_MAX[OUT_W-1:0];
            sat   = 1'b1;
        end else if (q_full < Q_MIN) begin
            q_sat = Q_MIN[OUT_W-1:0];
            sat   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_q   <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            w_q      <= '0;
            out_data <= '0;
            out_idx  <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                tile_q  <= c_in;
                shift_q <= shift;
                relu_q  <= relu_en;
                w_q     <= '0;
            end
            if (state_q == CALC) begin
                out_data <= q_sat;
                out_idx  <= w_q;
                out_sat  <= sat;
            end
            if (state_q == EMIT && out_ready && w_q != 2'd3) w_q <= w_q + 2'd1;
        end
    end

endmodule

// File: tb/tb_conv_pool_requant.sv
// Scoreboard bench for conv_pool_requant: a behavioural pooling/requant model queues
// expected outputs at capture; an independent monitor checks each output handshake.
module tb_conv_pool_requant;
    import npu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    conv_tile_t  c_in = '0;
    logic [3:0]  shift = '0;
    logic        relu_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_sat;
    logic        busy;
    logic        done;

    conv_pool_requant #(.IN_W(16), .OUT_W(8), .SHIFT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .c_in(c_in),
        .shift(shift), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_sat(out_sat), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int data; int idx; bit sat; } exp_t;
    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   tile[4][4];
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: manual
    bit   ready_man = 1'b1;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Pooling and requantisation straight from the arithmetic definition (floor division).
    function automatic exp_t model(input int t[4][4], input int sh, input bit rl, input int w);
        exp_t e;
        int rb, cb, m, r, d, q;
        rb = (w / 2) * 2;
        cb = (w % 2) * 2;
        m  = t[rb][cb];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (t[rb+i][cb+j] > m) m = t[rb+i][cb+j];
        if (rl && m < 0) m = 0;
        r = m + ((sh > 0) ? (2 ** (sh - 1)) : 0);
        d = 2 ** sh;
        if (r >= 0) q = r / d;
        else        q = -((-r + d - 1) / d);
        e.sat = 1'b0;
        if (q > 127)  begin q = 127;  e.sat = 1'b1; end
        if (q < -128) begin q = -128; e.sat = 1'b1; end
        e.data = q;
        e.idx  = w;
        return e;
    endfunction

    task automatic push_expected(input int sh, input bit rl);
        for (int w = 0; w < 4; w++) exp_q.push_back(model(tile, sh, rl, w));
    endtask

    task automatic drive_tile(input int sh, input bit rl);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) c_in[r][c] = 16'(tile[r][c]);
        shift   = 4'(sh);
        relu_en = rl;
    endtask

    task automatic scramble_inputs();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) c_in[r][c] = 16'($urandom);
        shift   = 4'($urandom);
        relu_en = 1'($urandom);
    endtask

    task automatic send_tile(input int sh, input bit rl);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) timeout("send_in_ready");
        else begin
            drive_tile(sh, rl);
            in_valid = 1'b1;
            push_expected(sh, rl);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            scramble_inputs();
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && in_ready) && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) timeout("drain");
    endtask

    task automatic wait_out(input int idx, input bit need_ready);
        int n = 0;
        @(negedge clk);
        while (!(out_valid && out_idx == 2'(idx) && (!need_ready || out_ready)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("wait_out");
    endtask

    function automatic int rand16(input int span);
        return int'($urandom_range(0, 2 * span)) - span;
    endfunction

    task automatic fill(input int v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tile[r][c] = v;
    endtask

    task automatic fill_random(input int span);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tile[r][c] = rand16(span);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (ready_mode == 0)      out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'($urandom);
        else                      out_ready = ready_man;
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability and done timing.
    int         hs_cnt = 0;
    bit         pend_done = 1'b0;
    bit         last_stall = 1'b0;
    logic [7:0] last_data;
    logic [1:0] last_idx;
    logic       last_sat;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hs_cnt     = 0;
            pend_done  = 1'b0;
            last_stall = 1'b0;
        end else begin
            if (pend_done || done) chk("done_pulse", done, pend_done);
            pend_done = 1'b0;
            if (out_valid) chk("busy_while_valid", busy, 1);
            if (out_valid && last_stall) begin
                chk("stall_data", out_data, last_data);
                chk("stall_idx", out_idx, last_idx);
                chk("stall_sat", out_sat, last_sat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL extra_output: idx %0d data %0d with empty scoreboard", out_idx, $signed(out_data));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", $signed(out_data), e.data);
                    chk("out_idx", out_idx, e.idx);
                    chk("out_sat", out_sat, e.sat);
                end
                hs_cnt++;
                if (hs_cnt == 4) begin
                    hs_cnt    = 0;
                    pend_done = 1'b1;
                end
                last_stall = 1'b0;
            end else if (out_valid) begin
                last_stall = 1'b1;
                last_data  = out_data;
                last_idx   = out_idx;
                last_sat   = out_sat;
            end else begin
                last_stall = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset values
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // T1: uniform tile, done timing checked by the monitor
        fill(100);
        send_tile(2, 1'b0);
        wait_drain();

        // T2: all-negative window with and without ReLU
        fill_random(500);
        tile[0][0] = -5; tile[0][1] = -9; tile[1][0] = -300; tile[1][1] = -2;
        send_tile(0, 1'b1);
        send_tile(0, 1'b0);
        wait_drain();

        // T3: saturation both ways and round-half-up
        fill_random(200);
        tile[0][0] = 1000; tile[0][1] = -7; tile[1][0] = 999; tile[1][1] = 3;
        tile[0][2] = -1000; tile[0][3] = -1000; tile[1][2] = -1000; tile[1][3] = -1000;
        tile[2][0] = 6; tile[2][1] = 1; tile[3][0] = -3; tile[3][1] = 0;
        send_tile(2, 1'b0);
        wait_drain();

        // T4: hold idx1 in EMIT with out_ready low
        ready_mode = 2;
        ready_man  = 1'b0;
        fill_random(3000);
        send_tile(3, 1'b0);
        wait_out(0, 1'b0);
        ready_man = 1'b1;
        wait_out(0, 1'b1);
        ready_man = 1'b0;
        wait_out(1, 1'b0);
        repeat (6) @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk("stall_idx_held", out_idx, 1);
        ready_man = 1'b1;
        wait_drain();
        ready_mode = 0;

        // T5a: in_valid pulse while busy is ignored
        fill_random(20000);
        send_tile(5, 1'b1);
        repeat (2) @(negedge clk);
        chk("busy_in_ready", in_ready, 0);
        scramble_inputs();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();

        // T5b: in_valid held high gives back-to-back tiles with one IDLE cycle between
        fill_random(1500);
        @(negedge clk);
        drive_tile(1, 1'b0);
        in_valid = 1'b1;
        push_expected(1, 1'b0);
        @(posedge clk);
        #1;
        fill_random(1500);
        drive_tile(4, 1'b1);
        push_expected(4, 1'b1);
        n = 0;
        @(negedge clk);
        while (!done && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout("held_done");
        @(negedge clk);
        chk("gap_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        @(negedge clk);
        chk("recapture_in_ready", in_ready, 0);
        chk("recapture_busy", busy, 1);
        wait_drain();

        // T6: asynchronous reset while idx2 is presented
        ready_mode = 2;
        ready_man  = 1'b1;
        fill_random(8000);
        send_tile(6, 1'b0);
        wait_out(1, 1'b1);
        ready_man = 1'b0;
        wait_out(2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_out_idx", out_idx, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_in_ready", in_ready, 0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("arst_hold_done", done, 0);
        end
        rst = 1'b0;
        ready_mode = 0;
        fill_random(4000);
        send_tile(3, 1'b1);
        wait_drain();

        // Randomised tiles with random backpressure
        ready_mode = 1;
        for (int k = 0; k < 25; k++) begin
            fill_random((k % 3 == 0) ? 600 : 32767);
            if (k % 5 == 0) tile[$urandom_range(0, 3)][$urandom_range(0, 3)] = -32768;
            send_tile(int'($urandom_range(0, 15)), 1'($urandom));
        end
        wait_drain();
        ready_mode = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
